// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: fetches instructions over a req/ack handshake, holds them for decode and computes the next PC.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        take_branch,
  input  logic        take_jump,
  output logic        inst_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_e;
  state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, pco_q, pco_d, br_tgt, j_tgt, next_pc;
  logic fetched, consume;
  assign imem_req   = state_q == FETCH;
  assign inst_valid = state_q == VALID;
  assign imem_addr  = pc_q;
  assign instr      = ir_q;
  assign opcode     = ir_q[31:26];
  assign funct      = ir_q[5:0];
  assign pc_out     = pco_q;
  assign pc_plus4   = pco_q + 32'd4;
  assign fetched    = imem_req & imem_ack;
  assign consume    = inst_valid & ~stall;
  assign j_tgt      = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign br_tgt     = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign next_pc    = take_jump ? j_tgt : take_branch ? br_tgt : pc_plus4;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    pco_d   = pco_q;
    if (state_q == IDLE) state_d = FETCH;
    if (fetched) begin
      ir_d    = imem_rdata;
      pco_d   = pc_q;
      state_d = VALID;
    end
    if (consume) begin
      pc_d    = next_pc;
      state_d = FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      pco_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pco_q   <= pco_d;
    end
  end
endmodule
